uart_rx_fsm: RTL and testbench
==============================

Name: uart_rx_fsm

Overview:
Frame controller for the UART receive path. Detects the start edge on RX_IN and runs the oversampling edge and bit counters. Sequences the sampler, deserializer, and the start, parity and stop checkers through one frame. Raises data_valid only for error-free frames. Sits between the RX pin synchroniser and the data_sampling/deserializer/parity_checker/strt_check/stop_check blocks in the RX top.

Parameters:
DATA_WIDTH, 8, payload bits per frame (bit_cnt 1..DATA_WIDTH)
PRESC_W, 6, width of Prescale and edge_cnt

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  asynchronous active-low reset
RX_IN  input  1  synchronised serial line, idle high
Prescale  input  PRESC_W  clocks per bit; legal values 8, 16, 32
PAR_EN  input  1  1 = frame carries a parity bit
par_err  input  1  from parity_checker, registered
strt_glitch  input  1  from start checker, registered
stp_err  input  1  from stop checker, registered
edge_cnt  output  PRESC_W  oversample position within current bit
bit_cnt  output  4  frame bit index: 0 = start, 1..8 = data, 9 = parity, 9/10 = stop
data_samp_en  output  1  sampler enable
strt_chk_en  output  1  start checker enable
deser_en  output  1  deserializer shift enable
parity_checker_enable  output  1  parity checker enable
stp_chk_en  output  1  stop checker enable
data_valid  output  1  one-cycle strobe: frame accepted

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, edge_cnt=0, bit_cnt=0, all enables and data_valid=0. Reset mid-frame abandons the frame; no data_valid.
- Prescale is latched into P on the IDLE->START transition. Changes mid-frame are ignored.
- Define CP = P/2+2, the cycle after the 3-sample majority window at edges P/2-1..P/2+1.
- Counters, active in all states except IDLE and ERR_CHK:
  - edge_cnt increments each clock.
  - At edge_cnt==P-1, edge_cnt wraps to 0 and bit_cnt increments.
- States: IDLE, START, DATA, PARITY, STOP, ERR_CHK. State register plus counters are the only flops; enables are decoded from them. data_valid is registered.
- IDLE: when RX_IN==0, go to START with edge_cnt=0 and bit_cnt=0.
- START:
  - strt_chk_en=1 when edge_cnt==CP.
  - At edge_cnt==P-1: if strt_glitch=1, go to IDLE (counters cleared); else go to DATA with bit_cnt=1.
- DATA:
  - deser_en=1 and parity_checker_enable=1 when edge_cnt==CP. The checker accumulates data bits.
  - At end of bit DATA_WIDTH: go to PARITY if PAR_EN, else STOP.
- PARITY:
  - parity_checker_enable=1 when edge_cnt==CP (bit_cnt=9).
  - At end of bit, go to STOP.
- STOP:
  - stp_chk_en=1 when edge_cnt==CP.
  - On the following cycle (edge_cnt==CP+1), go to ERR_CHK.
  - The remaining stop half-bit is absorbed in IDLE, since the line is high.
- ERR_CHK (1 cycle):
  - data_valid=1 iff stp_err==0 and (PAR_EN==0 or par_err==0).
  - Go to IDLE; counters cleared.
- data_samp_en=1 in START, DATA, PARITY and STOP.
- A falling RX_IN in the ERR_CHK cycle is not detected; it is caught the next cycle in IDLE. This supports back-to-back frames with a 1-bit stop.
- Frame length: 10 bits without parity, 11 with. data_valid occurs exactly (bits-1)*P + CP + 1 cycles after START entry.

Optional Feature:
- Macro: UART_RX_ERR_CNT_EN.
- When defined:
  - Adds output frame_err_cnt[7:0], reset 0.
  - Increments, saturating at 255, on each ERR_CHK cycle with data_valid=0 and on each START abort due to strt_glitch.
- When undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Prescale=8, PAR_EN=1, even parity, data 0xB3 LSB first, parity bit 1, stop 1 -> parity_checker_enable pulses at edge 6 of bits 1..9; data_valid=1 for exactly one cycle, 87 cycles after START entry.
- Same frame with parity bit 0 -> par_err=1 at ERR_CHK; data_valid stays 0; frame_err_cnt 0->1 when macro defined.
- Prescale=16, PAR_EN=0, data 0x5A, stop 1 -> no parity_checker_enable pulse in bit 9; stp_chk_en at bit 9 edge 10; data_valid one cycle, 155 cycles after START entry.
- RX_IN low for 2 cycles only, strt_glitch=1 at START end -> return to IDLE at edge 7 of bit 0; no deser_en pulse; no data_valid.
- RST driven low at bit_cnt=4 mid-frame -> all outputs 0 immediately (asynchronous); next frame after release is received correctly.
- Two back-to-back frames, 0x01 then 0xFF, Prescale=8, PAR_EN=1 -> two data_valid strobes; second frame's start edge is caught within one cycle of ERR_CHK.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: start detection, oversample/bit counters and checker sequencing.
// Optional frame error counter enabled with `define UART_RX_ERR_CNT_EN.
module uart_rx_fsm #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESC_W    = 6
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               RX_IN,
  input  logic [PRESC_W-1:0] Prescale,
  input  logic               PAR_EN,
  input  logic               par_err,
  input  logic               strt_glitch,
  input  logic               stp_err,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic [3:0]         bit_cnt,
  output logic               data_samp_en,
  output logic               strt_chk_en,
  output logic               deser_en,
  output logic               parity_checker_enable,
  output logic               stp_chk_en,
  output logic               data_valid
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]         frame_err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_ERR_CHK
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_edge_cnt;
  logic [PRESC_W-1:0] w_edge_nxt;
  logic [3:0]         r_bit_cnt;
  logic [3:0]         w_bit_nxt;
  logic               w_load_presc;
  logic [PRESC_W-1:0] w_cp;
  logic               w_at_cp;
  logic               w_last_edge;
  logic               w_counting;
  logic               w_frame_ok;

  // Checker strobe point: first cycle after the 3-sample majority window.
  assign w_cp        = (r_presc >> 1) + PRESC_W'(2);
  assign w_at_cp     = (r_edge_cnt == w_cp);
  assign w_last_edge = (r_edge_cnt == r_presc - PRESC_W'(1));
  assign w_counting  = (r_state != S_IDLE) && (r_state != S_ERR_CHK);
  assign w_frame_ok  = !stp_err && (!PAR_EN || !par_err);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
      r_presc    <= '0;
    end else begin
      r_state    <= w_next_state;
      r_edge_cnt <= w_edge_nxt;
      r_bit_cnt  <= w_bit_nxt;
      if (w_load_presc) begin
        r_presc <= Prescale;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_edge_nxt   = r_edge_cnt;
    w_bit_nxt    = r_bit_cnt;
    w_load_presc = 1'b0;

    if (w_counting) begin
      if (w_last_edge) begin
        w_edge_nxt = '0;
        w_bit_nxt  = r_bit_cnt + 4'd1;
      end else begin
        w_edge_nxt = r_edge_cnt + PRESC_W'(1);
      end
    end

    case (r_state)
      S_IDLE: begin
        if (!RX_IN) begin
          w_next_state = S_START;
          w_load_presc = 1'b1;
          w_edge_nxt   = '0;
          w_bit_nxt    = '0;
        end
      end
      S_START: begin
        if (w_last_edge) begin
          if (strt_glitch) begin
            w_next_state = S_IDLE;
            w_edge_nxt   = '0;
            w_bit_nxt    = '0;
          end else begin
            w_next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_last_edge && (r_bit_cnt == 4'(DATA_WIDTH))) begin
          w_next_state = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_last_edge) begin
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        // Leave after the stop sample; the rest of the stop bit is idle-high line time.
        if (w_at_cp) begin
          w_next_state = S_ERR_CHK;
        end
      end
      S_ERR_CHK: begin
        w_next_state = S_IDLE;
        w_edge_nxt   = '0;
        w_bit_nxt    = '0;
      end
      default: begin
        w_next_state = S_IDLE;
        w_edge_nxt   = '0;
        w_bit_nxt    = '0;
      end
    endcase
  end

  always_comb begin
    data_samp_en          = 1'b0;
    strt_chk_en           = 1'b0;
    deser_en              = 1'b0;
    parity_checker_enable = 1'b0;
    stp_chk_en            = 1'b0;
    data_valid            = 1'b0;
    case (r_state)
      S_START: begin
        data_samp_en = 1'b1;
        strt_chk_en  = w_at_cp;
      end
      S_DATA: begin
        data_samp_en          = 1'b1;
        deser_en              = w_at_cp;
        parity_checker_enable = w_at_cp;
      end
      S_PARITY: begin
        data_samp_en          = 1'b1;
        parity_checker_enable = w_at_cp;
      end
      S_STOP: begin
        data_samp_en = 1'b1;
        stp_chk_en   = w_at_cp;
      end
      // Decoded from the registered state and registered checker flags: a clean 1-cycle strobe.
      S_ERR_CHK: data_valid = w_frame_ok;
      default:   data_valid = 1'b0;
    endcase
  end

  assign edge_cnt = r_edge_cnt;
  assign bit_cnt  = r_bit_cnt;

`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] r_err_cnt;
  logic       w_err_event;

  assign w_err_event = ((r_state == S_ERR_CHK) && !w_frame_ok) ||
                       ((r_state == S_START) && w_last_edge && strt_glitch);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_err_cnt <= '0;
    end else if (w_err_event && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign frame_err_cnt = r_err_cnt;
`endif

  a_presc_legal: assert property (@(posedge CLK) disable iff (!RST)
    ((r_state == S_IDLE) && !RX_IN) |->
      ((Prescale == PRESC_W'(8)) || (Prescale == PRESC_W'(16)) || (Prescale == PRESC_W'(32))));

  a_valid_single: assert property (@(posedge CLK) disable iff (!RST)
    data_valid |=> !data_valid);

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: directed frames plus randomized frames against a timing model.
module tb_uart_rx_fsm;
  localparam int PW = 6;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          RX_IN = 1'b1;
  logic [PW-1:0] Prescale = 6'd8;
  logic          PAR_EN = 1'b0;
  logic          par_err = 1'b0;
  logic          strt_glitch = 1'b0;
  logic          stp_err = 1'b0;
  logic [PW-1:0] edge_cnt;
  logic [3:0]    bit_cnt;
  logic          data_samp_en, strt_chk_en, deser_en, parity_checker_enable, stp_chk_en, data_valid;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0]    frame_err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_err_cnt = 0;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESC_W(PW)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale), .PAR_EN(PAR_EN),
    .par_err(par_err), .strt_glitch(strt_glitch), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .data_samp_en(data_samp_en),
    .strt_chk_en(strt_chk_en), .deser_en(deser_en),
    .parity_checker_enable(parity_checker_enable), .stp_chk_en(stp_chk_en),
    .data_valid(data_valid)
`ifdef UART_RX_ERR_CNT_EN
    , .frame_err_cnt(frame_err_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         edge_c;
    int         bit_c;
    logic [5:0] en;   // {samp, strt, deser, parity, stop, valid}
  } exp_t;

  // Expected outputs t cycles after START entry, from frame geometry alone.
  function automatic exp_t model(input int t, input int p, input bit pen, input bit glitch, input bit ok);
    exp_t e;
    int cp, bits, terr, b, ed;
    cp   = p / 2 + 2;
    bits = pen ? 11 : 10;
    terr = (bits - 1) * p + cp + 1;
    e.edge_c = 0;
    e.bit_c  = 0;
    e.en     = '0;
    if (glitch) begin
      if (t < p) begin
        e.edge_c = t;
        e.en[5]  = 1'b1;
        e.en[4]  = (t == cp);
      end
    end else if (t < terr) begin
      b = t / p;
      ed = t % p;
      e.edge_c = ed;
      e.bit_c  = b;
      e.en[5]  = 1'b1;
      e.en[4]  = (b == 0) && (ed == cp);
      e.en[3]  = (b >= 1) && (b <= 8) && (ed == cp);
      e.en[2]  = (((b >= 1) && (b <= 8)) || (pen && (b == 9))) && (ed == cp);
      e.en[1]  = (b == bits - 1) && (ed == cp);
    end else if (t == terr) begin
      e.edge_c = cp + 1;
      e.bit_c  = bits - 1;
      e.en[0]  = ok;
    end
    return e;
  endfunction

  function automatic logic line_at(input int t, input int p, input bit pen, input logic [7:0] d,
                                   input logic pbit, input logic sbit);
    int b;
    b = t / p;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pen && (b == 9)) return pbit;
    if (b == (pen ? 10 : 9)) return sbit;
    return 1'b1;
  endfunction

  function automatic int legal_presc();
    int sel;
    sel = int'($urandom_range(2, 0));
    return (sel == 0) ? 8 : ((sel == 1) ? 16 : 32);
  endfunction

  // Entered just after a negedge with the DUT idle (or in ERR_CHK when armed).
  task automatic run_frame(input int p, input bit pen, input logic [7:0] d, input bit bad_par,
                           input bit bad_stop, input bit glitch, input bit armed, input bit chain,
                           input string tag);
    exp_t e;
    logic [5:0] act;
    logic pbit, sbit;
    bit ok;
    int cp, terr, last;
    pbit = (^d) ^ bad_par;
    sbit = !bad_stop;
    ok   = !bad_stop && (!pen || !bad_par);
    cp   = p / 2 + 2;
    terr = ((pen ? 11 : 10) - 1) * p + cp + 1;
    last = glitch ? p : (chain ? terr : terr + 1);
    Prescale    = PW'(p);
    PAR_EN      = pen;
    strt_glitch = glitch;
    par_err     = pen && bad_par;
    stp_err     = bad_stop;
    RX_IN       = 1'b0;
    if (armed) begin
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({edge_cnt, bit_cnt, data_samp_en, data_valid} !== '0) begin
        errors++;
        $display("FAIL %s gap_idle: got edge=%0d bit=%0d samp=%b dv=%b expected all 0",
                 tag, edge_cnt, bit_cnt, data_samp_en, data_valid);
      end
    end
    @(posedge CLK);
    for (int t = 0; t <= last; t++) begin
      @(negedge CLK);
      e = model(t, p, pen, glitch, ok);
      act = {data_samp_en, strt_chk_en, deser_en, parity_checker_enable, stp_chk_en, data_valid};
      checks++;
      if ((edge_cnt !== PW'(e.edge_c)) || (bit_cnt !== 4'(e.bit_c))) begin
        errors++;
        $display("FAIL %s counters t=%0d: got edge=%0d bit=%0d expected edge=%0d bit=%0d",
                 tag, t, edge_cnt, bit_cnt, e.edge_c, e.bit_c);
      end
      checks++;
      if (act !== e.en) begin
        errors++;
        $display("FAIL %s strobes t=%0d: got %b expected %b", tag, t, act, e.en);
      end
      if (t == 0) Prescale = PW'(legal_presc());
      if (glitch) RX_IN = 1'b1;
      else if (t >= terr) RX_IN = 1'b1;
      else RX_IN = line_at(t + 1, p, pen, d, pbit, sbit);
      if (chain && (t == terr)) RX_IN = 1'b0;
    end
    if (glitch || !ok) exp_err_cnt = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
`ifdef UART_RX_ERR_CNT_EN
    checks++;
    if (frame_err_cnt !== 8'(exp_err_cnt)) begin
      errors++;
      $display("FAIL %s err_cnt: got %0d expected %0d", tag, frame_err_cnt, exp_err_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    RST = 1'b0;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en, parity_checker_enable,
         stp_chk_en, data_valid} !== '0) begin
      errors++;
      $display("FAIL reset_hold: got edge=%0d bit=%0d samp=%b dv=%b expected all 0",
               edge_cnt, bit_cnt, data_samp_en, data_valid);
    end
    RX_IN = 1'b1;
    RST = 1'b1;
    @(negedge CLK);
    checks++;
    if ({edge_cnt, bit_cnt, data_samp_en, data_valid} !== '0) begin
      errors++;
      $display("FAIL reset_release_idle: got edge=%0d bit=%0d samp=%b expected all 0",
               edge_cnt, bit_cnt, data_samp_en);
    end
  endtask

  task automatic test_parity_frame();
    run_frame(8, 1'b1, 8'hB3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p8_par_good");
    run_frame(8, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "p8_par_bad");
  endtask

  task automatic test_no_parity();
    run_frame(16, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "p16_nopar");
    run_frame(32, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "p32_stop_bad");
  endtask

  task automatic test_start_glitch();
    run_frame(8, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "start_glitch");
  endtask

  task automatic test_reset_mid_frame();
    Prescale = 6'd8;
    PAR_EN = 1'b1;
    strt_glitch = 1'b0;
    par_err = 1'b0;
    stp_err = 1'b0;
    RX_IN = 1'b0;
    @(posedge CLK);
    for (int t = 0; t < 4 * 8 + 3; t++) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({edge_cnt, bit_cnt, data_samp_en, strt_chk_en, deser_en, parity_checker_enable,
         stp_chk_en, data_valid} !== '0) begin
      errors++;
      $display("FAIL reset_async: got edge=%0d bit=%0d samp=%b expected all 0",
               edge_cnt, bit_cnt, data_samp_en);
    end
    exp_err_cnt = 0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    run_frame(8, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_frame(8, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_first");
    run_frame(8, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    for (int n = 0; n < 14; n++) begin
      int gap;
      gap = int'($urandom_range(3, 0));
      for (int g = 0; g < gap; g++) begin
        @(negedge CLK);
        checks++;
        if ((data_samp_en !== 1'b0) || (data_valid !== 1'b0)) begin
          errors++;
          $display("FAIL rand_gap%0d: got samp=%b dv=%b expected 0 0", n, data_samp_en, data_valid);
        end
      end
      run_frame(legal_presc(), 1'($urandom_range(1, 0)), 8'($urandom),
                ($urandom_range(3, 0) == 0), ($urandom_range(3, 0) == 0),
                ($urandom_range(5, 0) == 0), 1'b0, 1'b0, $sformatf("rand%0d", n));
    end
  endtask

`ifdef UART_RX_ERR_CNT_EN
  task automatic test_err_cnt_saturate();
    for (int n = 0; n < 260; n++) begin
      run_frame(8, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "err_sat");
    end
  endtask
`endif

  initial begin
    test_reset();
    test_parity_frame();
    test_no_parity();
    test_start_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
`ifdef UART_RX_ERR_CNT_EN
    test_err_cnt_saturate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
